traffic_conflict_monitor: RTL and testbench

// Safety stage directly downstream of the traffic light FSM. Registers the six

---
 rtl/traffic_conflict_monitor.sv | 184 ++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers:
// registers the six lamp commands, checks each cycle for illegal patterns, and latches a fault with flashing red.
module traffic_conflict_monitor #(
  parameter int unsigned STARTUP_CYCLES = 8,
  parameter int unsigned MIN_YELLOW     = 3,
  parameter int unsigned FLASH_HALF     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_red_i,
  input  logic       ns_yellow_i,
  input  logic       ns_green_i,
  input  logic       ew_red_i,
  input  logic       ew_yellow_i,
  input  logic       ew_green_i,
  input  logic       fault_ack,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam logic [5:0] ALL_RED = 6'b100_100;

  typedef enum logic [1:0] {ST_STARTUP, ST_PASS, ST_FAULT} state_t;
  typedef enum logic [1:0] {LAMP_RED, LAMP_YELLOW, LAMP_GREEN} lamp_t;

  state_t        state, state_nxt;
  logic [5:0]    lamps, lamps_nxt;
  logic          fault_nxt;
  logic [2:0]    code_nxt, check_code;
  logic [SW-1:0] start_cnt, start_cnt_nxt;
  logic [FW-1:0] flash_cnt, flash_cnt_nxt;
  logic [YW-1:0] ns_ycnt, ns_ycnt_nxt, ew_ycnt, ew_ycnt_nxt;
  lamp_t         ns_prev, ns_prev_nxt, ew_prev, ew_prev_nxt;
  lamp_t         ns_cur, ew_cur;
  logic [5:0]    cmd;
  logic          conflict, invalid, bad_seq, short_yellow;

  function automatic logic one_lit(input logic [2:0] ryg);
    return (ryg == 3'b100) || (ryg == 3'b010) || (ryg == 3'b001);
  endfunction

  function automatic lamp_t decode(input logic [2:0] ryg);
    lamp_t l;
    l = LAMP_RED;
    if (ryg[1]) l = LAMP_YELLOW;
    if (ryg[0]) l = LAMP_GREEN;
    return l;
  endfunction

  function automatic logic legal_step(input lamp_t p, input lamp_t c);
    return (p == c) ||
           (p == LAMP_RED    && c == LAMP_GREEN)  ||
           (p == LAMP_GREEN  && c == LAMP_YELLOW) ||
           (p == LAMP_YELLOW && c == LAMP_RED);
  endfunction

  function automatic logic [YW-1:0] ycnt_step(input logic [YW-1:0] cnt, input logic yel);
    logic [YW-1:0] n;
    n = '0;
    if (yel) n = (cnt == YW'(MIN_YELLOW)) ? cnt : cnt + 1'b1;
    return n;
  endfunction

  assign cmd    = {ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i};
  assign ns_cur = decode(cmd[5:3]);
  assign ew_cur = decode(cmd[2:0]);

  assign conflict     = (cmd[4] | cmd[3]) & (cmd[1] | cmd[0]);
  assign invalid      = !one_lit(cmd[5:3]) || !one_lit(cmd[2:0]);
  assign bad_seq      = !legal_step(ns_prev, ns_cur) || !legal_step(ew_prev, ew_cur);
  assign short_yellow = (ns_prev == LAMP_YELLOW && ns_cur == LAMP_RED && ns_ycnt < YW'(MIN_YELLOW)) ||
                        (ew_prev == LAMP_YELLOW && ew_cur == LAMP_RED && ew_ycnt < YW'(MIN_YELLOW));

  // Lowest code wins when several checks fail together
  always_comb begin
    check_code = 3'd0;
    if (conflict)          check_code = 3'd1;
    else if (invalid)      check_code = 3'd2;
    else if (bad_seq)      check_code = 3'd3;
    else if (short_yellow) check_code = 3'd4;
  end

  always_comb begin
    state_nxt     = state;
    lamps_nxt     = lamps;
    fault_nxt     = fault;
    code_nxt      = fault_code;
    start_cnt_nxt = start_cnt;
    flash_cnt_nxt = flash_cnt;
    ns_ycnt_nxt   = ns_ycnt;
    ew_ycnt_nxt   = ew_ycnt;
    ns_prev_nxt   = ns_prev;
    ew_prev_nxt   = ew_prev;
    case (state)
      ST_STARTUP: begin
        lamps_nxt   = ALL_RED;
        ns_ycnt_nxt = '0;
        ew_ycnt_nxt = '0;
        ns_prev_nxt = LAMP_RED;
        ew_prev_nxt = LAMP_RED;
        if (start_cnt == SW'(STARTUP_CYCLES - 1)) begin
          state_nxt     = ST_PASS;
          start_cnt_nxt = '0;
        end else begin
          start_cnt_nxt = start_cnt + 1'b1;
        end
      end
      ST_PASS: begin
        if (check_code != 3'd0) begin
          state_nxt     = ST_FAULT;
          fault_nxt     = 1'b1;
          code_nxt      = check_code;
          lamps_nxt     = ALL_RED;
          flash_cnt_nxt = '0;
        end else begin
          lamps_nxt   = cmd;
          ns_prev_nxt = ns_cur;
          ew_prev_nxt = ew_cur;
          ns_ycnt_nxt = ycnt_step(ns_ycnt, ns_yellow_i);
          ew_ycnt_nxt = ycnt_step(ew_ycnt, ew_yellow_i);
        end
      end
      ST_FAULT: begin
        if (fault_ack && cmd == ALL_RED) begin
          state_nxt     = ST_STARTUP;
          fault_nxt     = 1'b0;
          code_nxt      = 3'd0;
          lamps_nxt     = ALL_RED;
          start_cnt_nxt = '0;
          flash_cnt_nxt = '0;
          ns_ycnt_nxt   = '0;
          ew_ycnt_nxt   = '0;
          ns_prev_nxt   = LAMP_RED;
          ew_prev_nxt   = LAMP_RED;
        end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
          // Both reds always carry the same level, so toggling from the NS bit is enough
          flash_cnt_nxt = '0;
          lamps_nxt     = {~lamps[5], 2'b00, ~lamps[5], 2'b00};
        end else begin
          flash_cnt_nxt = flash_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_STARTUP;
      lamps      <= ALL_RED;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      start_cnt  <= '0;
      flash_cnt  <= '0;
      ns_ycnt    <= '0;
      ew_ycnt    <= '0;
      ns_prev    <= LAMP_RED;
      ew_prev    <= LAMP_RED;
    end else begin
      state      <= state_nxt;
      lamps      <= lamps_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
      start_cnt  <= start_cnt_nxt;
      flash_cnt  <= flash_cnt_nxt;
      ns_ycnt    <= ns_ycnt_nxt;
      ew_ycnt    <= ew_ycnt_nxt;
      ns_prev    <= ns_prev_nxt;
      ew_prev    <= ew_prev_nxt;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: startup timing, pass-through,
// each fault code and its priority, fault flashing, acknowledge and reset recovery.
module tb_traffic_conflict_monitor;

  localparam logic [5:0] ALL_RED = 6'b100_100;
  localparam logic [5:0] NS_G    = 6'b001_100;
  localparam logic [5:0] NS_Y    = 6'b010_100;
  localparam logic [5:0] EW_G    = 6'b100_001;
  localparam logic [5:0] EW_Y    = 6'b100_010;
  localparam logic [5:0] BOTH_G  = 6'b001_001;

  logic       clk;
  logic       reset;
  logic [5:0] stim;
  logic       ack;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       fault;
  logic [2:0] fault_code;
  logic [5:0] lamps_o;

  int n_cmp = 0;
  int n_err = 0;

  traffic_conflict_monitor #(
    .STARTUP_CYCLES(8),
    .MIN_YELLOW(3),
    .FLASH_HALF(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ns_red_i(stim[5]),
    .ns_yellow_i(stim[4]),
    .ns_green_i(stim[3]),
    .ew_red_i(stim[2]),
    .ew_yellow_i(stim[1]),
    .ew_green_i(stim[0]),
    .fault_ack(ack),
    .ns_red(ns_red),
    .ns_yellow(ns_yellow),
    .ns_green(ns_green),
    .ew_red(ew_red),
    .ew_yellow(ew_yellow),
    .ew_green(ew_green),
    .fault(fault),
    .fault_code(fault_code)
  );

  assign lamps_o = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    reset = 1'b0;
    stim  = ALL_RED;
    ack   = 1'b0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stim  = ALL_RED;
    ack   = 1'b0;
    tick();
    n_cmp++;
    if (lamps_o !== ALL_RED) begin n_err++; $display("FAIL reset_lamps: got %b want %b", lamps_o, ALL_RED); end
    n_cmp++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++;
    if (fault_code !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", fault_code); end
    tick();
    #4;
    reset = 1'b1;
    stim  = NS_G;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (lamps_o !== ALL_RED) begin n_err++; $display("FAIL startup_red[%0d]: got %b want %b", i, lamps_o, ALL_RED); end
    end
    tick();
    n_cmp++;
    if (lamps_o !== NS_G) begin n_err++; $display("FAIL first_pass: got %b want %b", lamps_o, NS_G); end
    n_cmp++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL first_pass_fault: got %b want 0", fault); end
  endtask

  task automatic test_legal_cycle();
    logic [5:0] v;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 18; i++) begin
        if (i < 5)       v = NS_G;
        else if (i < 8)  v = NS_Y;
        else if (i == 8) v = ALL_RED;
        else if (i < 14) v = EW_G;
        else if (i < 17) v = EW_Y;
        else             v = ALL_RED;
        stim = v;
        ack  = (r == 0 && i == 8);
        tick();
        ack = 1'b0;
        n_cmp++;
        if (lamps_o !== v) begin n_err++; $display("FAIL legal_lamps[%0d.%0d]: got %b want %b", r, i, lamps_o, v); end
        n_cmp++;
        if (fault !== 1'b0) begin n_err++; $display("FAIL legal_fault[%0d.%0d]: got %b want 0", r, i, fault); end
      end
    end
  endtask

  task automatic test_conflict_flash();
    logic [5:0] exp;
    reset_and_start();
    stim = BOTH_G;
    for (int k = 0; k < 15; k++) begin
      tick();
      exp = (((k / 5) % 2) == 0) ? ALL_RED : 6'b000_000;
      n_cmp++;
      if (lamps_o !== exp) begin n_err++; $display("FAIL flash_lamps[%0d]: got %b want %b", k, lamps_o, exp); end
      n_cmp++;
      if (fault !== 1'b1 || fault_code !== 3'd1) begin
        n_err++; $display("FAIL conflict_code[%0d]: got fault=%b code=%0d want fault=1 code=1", k, fault, fault_code);
      end
    end
  endtask

  task automatic test_short_yellow();
    reset_and_start();
    stim = NS_G; tick();
    stim = NS_Y; tick();
    tick();
    n_cmp++;
    if (lamps_o !== NS_Y) begin n_err++; $display("FAIL short_yellow_pre: got %b want %b", lamps_o, NS_Y); end
    stim = ALL_RED; tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      n_err++; $display("FAIL short_yellow_code: got fault=%b code=%0d want fault=1 code=4", fault, fault_code);
    end
  endtask

  task automatic test_bad_sequence();
    reset_and_start();
    stim = NS_G; tick();
    n_cmp++;
    if (lamps_o !== NS_G) begin n_err++; $display("FAIL bad_seq_pre: got %b want %b", lamps_o, NS_G); end
    stim = ALL_RED; tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      n_err++; $display("FAIL bad_seq_code: got fault=%b code=%0d want fault=1 code=3", fault, fault_code);
    end
  endtask

  task automatic test_priority();
    reset_and_start();
    stim = EW_G; tick();
    n_cmp++;
    if (lamps_o !== EW_G || fault !== 1'b0) begin
      n_err++; $display("FAIL priority_pre: got lamps=%b fault=%b want lamps=%b fault=0", lamps_o, fault, EW_G);
    end
    // NS red->yellow is illegal and also conflicts with EW green
    stim = 6'b010_001; tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      n_err++; $display("FAIL priority_code: got fault=%b code=%0d want fault=1 code=1", fault, fault_code);
    end
    n_cmp++;
    if ((lamps_o & 6'b011_011) !== 6'b0) begin n_err++; $display("FAIL priority_lamps: got %b want no yellow/green", lamps_o); end
  endtask

  task automatic test_invalid_and_ack();
    reset_and_start();
    stim = 6'b110_100; tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      n_err++; $display("FAIL invalid_code: got fault=%b code=%0d want fault=1 code=2", fault, fault_code);
    end
    stim = NS_G; ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      n_err++; $display("FAIL ack_rejected: got fault=%b code=%0d want fault=1 code=2", fault, fault_code);
    end
    n_cmp++;
    if ((lamps_o & 6'b011_011) !== 6'b0) begin n_err++; $display("FAIL ack_rejected_lamps: got %b want no yellow/green", lamps_o); end
    stim = ALL_RED; ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || lamps_o !== ALL_RED) begin
      n_err++; $display("FAIL ack_accepted: got fault=%b code=%0d lamps=%b want fault=0 code=0 lamps=%b", fault, fault_code, lamps_o, ALL_RED);
    end
    stim = NS_G;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (lamps_o !== ALL_RED) begin n_err++; $display("FAIL ack_startup[%0d]: got %b want %b", i, lamps_o, ALL_RED); end
    end
    tick();
    n_cmp++;
    if (lamps_o !== NS_G || fault !== 1'b0) begin
      n_err++; $display("FAIL ack_pass: got lamps=%b fault=%b want lamps=%b fault=0", lamps_o, fault, NS_G);
    end
  endtask

  task automatic test_reset_mid_fault();
    reset_and_start();
    stim = BOTH_G;
    tick();
    repeat (6) tick();
    n_cmp++;
    if (lamps_o !== 6'b000_000 || fault !== 1'b1) begin
      n_err++; $display("FAIL midfault_dark: got lamps=%b fault=%b want lamps=000000 fault=1", lamps_o, fault);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (lamps_o !== ALL_RED || fault !== 1'b0 || fault_code !== 3'd0) begin
      n_err++; $display("FAIL midfault_reset: got lamps=%b fault=%b code=%0d want lamps=%b fault=0 code=0", lamps_o, fault, fault_code, ALL_RED);
    end
    reset = 1'b1;
    stim  = ALL_RED;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (lamps_o !== ALL_RED || fault !== 1'b0) begin
        n_err++; $display("FAIL post_reset_solid[%0d]: got lamps=%b fault=%b want lamps=%b fault=0", i, lamps_o, fault, ALL_RED);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict_flash();
    test_short_yellow();
    test_bad_sequence();
    test_priority();
    test_invalid_and_ack();
    test_reset_mid_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
